// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encoding and IRQ vector shared by
// the mc_controller slice.
package mc_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDO = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STO = 4'h3;
  localparam logic [3:0] OP_PRE = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_LDM = 4'h6;
  localparam logic [3:0] OP_ADN = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  // PC value the datapath loads while in S_IRQ
  localparam logic [7:0] IRQ_VEC = 8'h04;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_OPRD   = 5'd3,
    S_MEMRD  = 5'd4,
    S_MEMWR  = 5'd5,
    S_EXEC   = 5'd6,
    S_JLD    = 5'd7,
    S_JINC   = 5'd8,
    S_HALT   = 5'd9,
    S_IRQ    = 5'd10
  } state_e;

endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: combinational opcode classifier; illegal opcodes are
// folded to NOP so the controller never sees them.
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] ins,
  output logic [3:0]     op,
  output logic           illegal,
  output logic           is_nop,
  output logic           is_hlt,
  output logic           is_mem,
  output logic           is_exec,
  output logic           is_jmp
);

  logic hi_set;

  if (OPW > 4) begin : g_hi
    assign hi_set = |ins[OPW-1:4];
  end else begin : g_nohi
    assign hi_set = 1'b0;
  end

  always_comb begin
    illegal = hi_set || (ins[3:0] inside {4'hC, 4'hD, 4'hE});
    op      = illegal ? OP_NOP : ins[3:0];
    is_nop  = (op == OP_NOP);
    is_hlt  = (op == OP_HLT);
    is_mem  = op inside {OP_LDO, OP_LDA, OP_STO};
    is_exec = op inside {OP_PRE, OP_ADD, OP_LDM,
                         OP_ADN, OP_INC, OP_DEC};
    is_jmp  = op inside {OP_JMP, OP_JZ};
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle CPU control FSM.
// Optional interrupt entry enabled by defining CTRL_IRQ_EN.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int STATE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPW-1:0]     ins,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               run,
  output logic               pc_en,
  output logic               pc_in,
  output logic               ir_load,
  output logic               ac_ena,
  output logic               write_r,
  output logic               read_r,
  output logic               ram_ena,
  output logic               ram_read,
  output logic               ram_write,
  output logic               rom_ena,
  output logic               rom_read,
  output logic               ad_sel,
  output logic               im_int,
  output logic [STATE_W-1:0] state,
  output logic               halted,
  output logic               illegal
`ifdef CTRL_IRQ_EN
  ,
  input  logic               irq,
  output logic               irq_ack
`endif
);

  state_e state_q, state_d, fetch_nxt;
  logic [3:0] op;
  logic dec_ill, is_nop, is_hlt;
  logic is_mem, is_exec, is_jmp;
  logic irq_req;

  mc_decode #(.OPW(OPW)) u_dec (
    .ins     (ins),
    .op      (op),
    .illegal (dec_ill),
    .is_nop  (is_nop),
    .is_hlt  (is_hlt),
    .is_mem  (is_mem),
    .is_exec (is_exec),
    .is_jmp  (is_jmp)
  );

`ifdef CTRL_IRQ_EN
  assign irq_req = irq;
`else
  assign irq_req = 1'b0;
`endif

  // every return to FETCH is an interrupt window
  assign fetch_nxt = irq_req ? S_IRQ : S_FETCH;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_nop:  state_d = fetch_nxt;
          is_hlt:  state_d = S_HALT;
          is_exec: state_d = S_EXEC;
          is_mem:  state_d = S_OPRD;
          is_jmp: begin
            if (op == OP_JMP || zero) state_d = S_JLD;
            else                      state_d = S_JINC;
          end
          default: state_d = fetch_nxt;
        endcase
      end
      S_OPRD:
        state_d = (op == OP_STO) ? S_MEMWR : S_MEMRD;
      S_MEMRD: if (mem_ready) state_d = S_EXEC;
      S_MEMWR: if (mem_ready) state_d = S_EXEC;
      S_EXEC:  state_d = fetch_nxt;
      S_JLD:   state_d = fetch_nxt;
      S_JINC:  state_d = fetch_nxt;
      S_HALT: begin
        if (irq_req)  state_d = S_IRQ;
        else if (run) state_d = S_FETCH;
      end
`ifdef CTRL_IRQ_EN
      S_IRQ:   state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    pc_in     = 1'b0;
    ir_load   = 1'b0;
    ac_ena    = 1'b0;
    write_r   = 1'b0;
    read_r    = 1'b0;
    ram_ena   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    rom_ena   = 1'b0;
    rom_read  = 1'b0;
    ad_sel    = 1'b0;
    im_int    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        ir_load  = 1'b1;
      end
      S_DECODE: begin
        pc_en   = 1'b1;
        im_int  = (op == OP_ADN);
        illegal = dec_ill;
      end
      S_OPRD: begin
        rom_ena  = 1'b1;
        rom_read = 1'b1;
        ac_ena   = 1'b1;
        pc_en    = 1'b1;
      end
      S_MEMRD: begin
        ad_sel   = 1'b1;
        write_r  = 1'b1;
        ac_ena   = 1'b1;
        rom_ena  = (op == OP_LDO);
        rom_read = (op == OP_LDO);
        ram_ena  = (op == OP_LDA);
        ram_read = (op == OP_LDA);
      end
      S_MEMWR: begin
        ad_sel    = 1'b1;
        read_r    = 1'b1;
        ram_ena   = 1'b1;
        ram_write = 1'b1;
      end
      S_EXEC: begin
        ac_ena  = is_exec;
        read_r  = op inside {OP_PRE, OP_ADD};
        write_r = (op == OP_LDM);
      end
      S_JLD: begin
        pc_in    = 1'b1;
        rom_ena  = 1'b1;
        rom_read = 1'b1;
      end
      S_JINC:  pc_en  = 1'b1;
      S_HALT:  halted = 1'b1;
`ifdef CTRL_IRQ_EN
      S_IRQ: begin
        pc_in   = 1'b1;
        irq_ack = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed vectors with hand-computed enables,
// latencies and status for mc_controller (OPW=8).
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  localparam logic [12:0] E_PCEN  = 13'h1000;
  localparam logic [12:0] E_PCIN  = 13'h0800;
  localparam logic [12:0] E_IRLD  = 13'h0400;
  localparam logic [12:0] E_ACEN  = 13'h0200;
  localparam logic [12:0] E_WR    = 13'h0100;
  localparam logic [12:0] E_RD    = 13'h0080;
  localparam logic [12:0] E_RAMEN = 13'h0040;
  localparam logic [12:0] E_RAMRD = 13'h0020;
  localparam logic [12:0] E_RAMWR = 13'h0010;
  localparam logic [12:0] E_ROMEN = 13'h0008;
  localparam logic [12:0] E_ROMRD = 13'h0004;
  localparam logic [12:0] E_ADSEL = 13'h0002;
  localparam logic [12:0] E_IMINT = 13'h0001;
  localparam logic [15:0] UNSEEN  = 16'hFFFF;

  logic clk = 1'b0;
  logic rst, zero, mem_ready, run;
  logic [7:0] ins;
  logic pc_en, pc_in, ir_load, ac_ena, write_r, read_r;
  logic ram_ena, ram_read, ram_write, rom_ena, rom_read;
  logic ad_sel, im_int, halted, illegal;
  logic [4:0] state;
`ifdef CTRL_IRQ_EN
  logic irq, irq_ack;
`endif
  logic [12:0] en;

  int n_chk = 0;
  int n_fail = 0;
  int lat, rr_cnt, ill_cnt;
  logic [15:0] en_log [32];

  assign en = {pc_en, pc_in, ir_load, ac_ena, write_r, read_r,
               ram_ena, ram_read, ram_write, rom_ena, rom_read,
               ad_sel, im_int};

  mc_controller #(.OPW(8), .STATE_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .zero      (zero),
    .mem_ready (mem_ready),
    .run       (run),
    .pc_en     (pc_en),
    .pc_in     (pc_in),
    .ir_load   (ir_load),
    .ac_ena    (ac_ena),
    .write_r   (write_r),
    .read_r    (read_r),
    .ram_ena   (ram_ena),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .rom_ena   (rom_ena),
    .rom_read  (rom_read),
    .ad_sel    (ad_sel),
    .im_int    (im_int),
    .state     (state),
    .halted    (halted),
    .illegal   (illegal)
`ifdef CTRL_IRQ_EN
    ,
    .irq       (irq),
    .irq_ack   (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // run one instruction from FETCH back to FETCH, logging enables
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic z, input int waits,
                        input int exp_lat);
    logic [4:0] st;
    int waited;
    ins = op;
    zero = z;
    lat = 0;
    waited = 0;
    rr_cnt = 0;
    ill_cnt = 0;
    foreach (en_log[i]) en_log[i] = UNSEEN;
    do begin
      st = state;
      en_log[st] = {3'b000, en};
      rr_cnt += int'(ram_read);
      ill_cnt += int'(illegal);
      if ((st == S_MEMRD || st == S_MEMWR) && waited < waits) begin
        mem_ready = 1'b0;
        waited++;
      end else begin
        mem_ready = 1'b1;
      end
      tick();
      lat++;
    end while (state != S_FETCH && lat < 40);
    mem_ready = 1'b1;
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    int ok;
    rst = 1'b1;
    ins = 8'h00;
    zero = 1'b0;
    mem_ready = 1'b1;
    run = 1'b0;
`ifdef CTRL_IRQ_EN
    irq = 1'b0;
`endif
    tick();
    tick();
    check("rst_state", state, S_IDLE);
    check("rst_en", en, 13'h0);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_to_fetch", state, S_FETCH);
    check("fetch_en", en, E_ROMEN | E_ROMRD | E_IRLD);

    mem_ready = 1'b0;
    tick();
    tick();
    check("fetch_hold", state, S_FETCH);
    mem_ready = 1'b1;

    run_op("nop", 8'h00, 1'b0, 0, 2);
    check("nop_dec", en_log[S_DECODE], E_PCEN);
    check("nop_ill", ill_cnt, 0);

    run_op("inc", 8'h08, 1'b0, 0, 3);
    check("inc_exec", en_log[S_EXEC], E_ACEN);
    run_op("dec", 8'h09, 1'b0, 0, 3);
    check("dec_exec", en_log[S_EXEC], E_ACEN);
    run_op("adn", 8'h07, 1'b0, 0, 3);
    check("adn_dec", en_log[S_DECODE], E_PCEN | E_IMINT);
    check("adn_exec", en_log[S_EXEC], E_ACEN);
    run_op("pre", 8'h04, 1'b0, 0, 3);
    check("pre_exec", en_log[S_EXEC], E_ACEN | E_RD);
    run_op("add", 8'h05, 1'b0, 0, 3);
    check("add_exec", en_log[S_EXEC], E_ACEN | E_RD);
    run_op("ldm", 8'h06, 1'b0, 0, 3);
    check("ldm_exec", en_log[S_EXEC], E_ACEN | E_WR);

    run_op("jmp", 8'h0A, 1'b0, 0, 3);
    check("jmp_jld", en_log[S_JLD], E_PCIN | E_ROMEN | E_ROMRD);
    run_op("jz1", 8'h0B, 1'b1, 0, 3);
    check("jz1_jld", en_log[S_JLD], E_PCIN | E_ROMEN | E_ROMRD);
    check("jz1_nojinc", en_log[S_JINC], UNSEEN);
    run_op("jz0", 8'h0B, 1'b0, 0, 3);
    check("jz0_jinc", en_log[S_JINC], E_PCEN);
    check("jz0_nojld", en_log[S_JLD], UNSEEN);

    run_op("ldo", 8'h01, 1'b0, 0, 5);
    check("ldo_oprd", en_log[S_OPRD],
          E_ROMEN | E_ROMRD | E_ACEN | E_PCEN);
    check("ldo_memrd", en_log[S_MEMRD],
          E_ADSEL | E_WR | E_ACEN | E_ROMEN | E_ROMRD);
    check("ldo_exec", en_log[S_EXEC], 13'h0);

    run_op("lda", 8'h02, 1'b0, 3, 8);
    check("lda_memrd", en_log[S_MEMRD],
          E_ADSEL | E_WR | E_ACEN | E_RAMEN | E_RAMRD);
    check("lda_rdcnt", rr_cnt, 4);

    run_op("sto", 8'h03, 1'b0, 1, 6);
    check("sto_memwr", en_log[S_MEMWR],
          E_ADSEL | E_RD | E_RAMEN | E_RAMWR);
    check("sto_exec", en_log[S_EXEC], 13'h0);

    run_op("ill15", 8'h15, 1'b0, 0, 2);
    check("ill15_cnt", ill_cnt, 1);
    run_op("ill0c", 8'h0C, 1'b0, 0, 2);
    check("ill0c_cnt", ill_cnt, 1);
    check("ill0c_dec", en_log[S_DECODE], E_PCEN);

    ins = 8'h0F;
    tick();
    tick();
    check("hlt_state", state, S_HALT);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state == S_HALT && halted && en == 13'h0) ok++;
    end
    check("hlt_hold", ok, 10);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("hlt_run", state, S_FETCH);
    check("hlt_clear", halted, 1'b0);

`ifdef CTRL_IRQ_EN
    ins = 8'h08;
    tick();
    tick();
    check("irq_exec", state, S_EXEC);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    check("irq_state", state, S_IRQ);
    check("irq_ack", irq_ack, 1'b1);
    check("irq_en", en, E_PCIN);
    tick();
    check("irq_ret", state, S_FETCH);
    ins = 8'h0F;
    tick();
    tick();
    irq = 1'b1;
    run = 1'b1;
    tick();
    irq = 1'b0;
    run = 1'b0;
    check("irq_halt_win", state, S_IRQ);
    tick();
    check("irq_halt_ret", state, S_FETCH);
`endif

    ins = 8'h03;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("rstmid_state", state, S_MEMWR);
    check("rstmid_wr", ram_write, 1'b1);
    rst = 1'b1;
    tick();
    check("rstmid_wr0", ram_write, 1'b0);
    check("rstmid_idle", state, S_IDLE);
    check("rstmid_en", en, 13'h0);
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("rstmid_fetch", state, S_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter OPW, default 4: instruction opcode input width; legal range 4..8.
REQ-002 Parameter STATE_W, default 5: width of the state output.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ins  in  OPW  opcode of the instruction currently held in IR.
REQ-006 zero  in  1  accumulator-zero flag, sampled in DECODE.
REQ-007 mem_ready  in  1  memory-access complete, sampled in FETCH, MEMRD and MEMWR.
REQ-008 run  in  1  resume request; leaves HALT.
REQ-009 irq  in  1  interrupt request; present only with CTRL_IRQ_EN.
REQ-010 Enable outputs, all 1 bit: pc_en, pc_in, ir_load, ac_ena, write_r, read_r, ram_ena, ram_read, ram_write, rom_ena, rom_read, ad_sel, im_int.
REQ-011 Status outputs: state (STATE_W), halted (1), illegal (1); irq_ack (1) only with CTRL_IRQ_EN.

Function
REQ-012 Opcode decode SHALL use ins[3:0]: NOP=0, LDO=1, LDA=2, STO=3, PRE=4, ADD=5, LDM=6, ADN=7, INC=8, DEC=9, JMP=A, JZ=B, HLT=F.
REQ-013 An opcode with any nonzero bit in ins[OPW-1:4], or with value C/D/E, SHALL execute as NOP and pulse illegal for one cycle in DECODE.
REQ-014 States: IDLE, FETCH, DECODE, OPRD, MEMRD, MEMWR, EXEC, JLD, JINC, HALT, IRQ; encodings are in the package; state output equals the current encoding.
REQ-015 IDLE -> FETCH unconditionally.
REQ-016 FETCH: rom_ena=rom_read=ir_load=1; hold while mem_ready=0; on mem_ready=1 go to DECODE.
REQ-017 DECODE: pc_en=1 for exactly one cycle. Next state:
 - NOP/illegal -> FETCH
 - HLT -> HALT
 - INC/DEC/ADN -> EXEC; im_int=1 for ADN
 - JMP -> JLD
 - JZ -> JLD if zero=1, else JINC
 - PRE/ADD/LDM -> EXEC
 - LDO/LDA/STO -> OPRD
REQ-018 OPRD: rom_ena=rom_read=ac_ena=pc_en=1 for one cycle. LDO/LDA -> MEMRD; STO -> MEMWR.
REQ-019 MEMRD: ad_sel=write_r=ac_ena=1; LDO asserts rom_ena/rom_read, LDA asserts ram_ena/ram_read; hold until mem_ready=1, then -> EXEC.
REQ-020 MEMWR: ad_sel=read_r=ram_ena=ram_write=1; hold until mem_ready=1, then -> EXEC.
REQ-021 EXEC: one cycle.
 - ac_ena=1 for INC/DEC/ADN/PRE/ADD/LDM.
 - read_r=1 for PRE/ADD.
 - write_r=1 for LDM.
 - No enables for LDO/LDA/STO.
 - Always -> FETCH.
REQ-022 JLD: pc_in=1, rom_ena=rom_read=1, one cycle -> FETCH.
REQ-023 JINC: pc_en=1 (skip target byte), one cycle -> FETCH.
REQ-024 HALT: all enables 0, halted=1; run=1 -> FETCH, otherwise remain in HALT.
REQ-025 Every output not listed for a state SHALL be 0 in that state; outputs are decoded combinationally from state and ins.
REQ-026 An unreachable state encoding SHALL go to IDLE with all enables 0.
REQ-027 Instruction latency in cycles, with zero memory wait: NOP 2, INC/DEC/ADN/PRE/ADD/LDM 3, JMP/JZ 3, LDO/LDA/STO 5. Each memory wait cycle adds exactly one cycle.

Reset
REQ-028 With rst=1 at a rising edge: next state = IDLE, all enables 0, halted=0, illegal=0, irq_ack=0; rst is sampled only on clk.
REQ-029 rst asserted mid-access, including while waiting on mem_ready, SHALL abandon the access; ram_write SHALL be 0 in the cycle after the reset edge.

Configuration
REQ-030 Macro CTRL_IRQ_EN. When defined:
 - irq sampled in FETCH entry (from EXEC, JLD, JINC, DECODE->FETCH) and in HALT; irq=1 -> IRQ state instead of FETCH.
 - IRQ: pc_in=1, irq_ack=1, one cycle -> FETCH.
 - irq ignored in all other states.
 - irq and run both high in HALT: IRQ wins.
REQ-031 When undefined: irq and irq_ack ports absent; IRQ state unreachable; behaviour as REQ-015..027.

Structure
REQ-032 Package mc_ctrl_pkg SHALL hold opcode constants, the state encoding typedef and the IRQ vector constant.
REQ-033 One sub-module, mc_decode: combinational opcode classifier (illegal, mem-class, exec-class, jump-class).

Verification
REQ-034 Reset: rst=1 for 2 cycles, then 0 -> state IDLE, then FETCH on the next edge; all enables 0 during reset.
REQ-035 LDA with mem_ready low 3 cycles in MEMRD -> ram_read=1 for 4 cycles; total latency 8; then FETCH.
REQ-036 JZ with zero=1 -> JLD with pc_in=1; JZ with zero=0 -> JINC with pc_en=1; each 3 cycles.
REQ-037 ins=8'h15 with OPW=8 -> illegal=1 for one cycle; returns to FETCH after 2 cycles.
REQ-038 HLT then run=0 for 10 cycles -> halted=1 throughout; run=1 -> FETCH next cycle.
REQ-039 CTRL_IRQ_EN: irq=1 during EXEC of INC -> IRQ (irq_ack=1, pc_in=1) then FETCH; STO interrupted by rst in MEMWR -> ram_write=0 after the edge.
